csa_operand_sequencer: RTL and testbench

- Front-end and sequencer for the 8-bit carry-skip adder slice. Accepts two NBYTES-wide operands as a byte stream and drives the adder one byte per cycle, LSB first, chaining the carry through a register.
- Buffers the sum bytes and streams them out with a ready/valid handshake.
- Lets the 8-bit combinational adder perform multi-byte additions inside the tile.

---
 rtl/csa_operand_sequencer.sv | 170 +++++++++++++++++
 tb/tb_csa_operand_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/csa_operand_sequencer.sv
// csa_operand_sequencer
// Front-end and sequencer for an 8-bit carry-skip adder slice. Two NBYTES-wide
// operands arrive as a byte stream (A bytes then B bytes, LSB first). The block
// then drives the external combinational adder one byte per cycle, chaining the
// carry through a register. Finally it streams the sum bytes out with a
// ready/valid handshake.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_data/in_valid     operand byte stream; in_ready high in load states
//   in_cin               whole-addition carry-in, sampled with A byte 0
//   add_a/add_b/add_cin  registered operands to the external adder
//   add_sum/add_cout     combinational result from the external adder
//   out_data/out_valid   sum byte stream, LSB first; out_ready from downstream
//   out_last/out_cout    final-byte marker and final carry (valid with out_last)
//   busy                 low only when idle in LOAD_A with nothing loaded
module csa_operand_sequencer #(
  parameter int NBYTES = 4,
  parameter int CW     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_cin,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_cin,
  input  logic [7:0] add_sum,
  input  logic       add_cout,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       out_cout,
  output logic       busy
);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, ADD, DRAIN} state_e;

  // Buffers span the full index range so every idx value selects a real entry;
  // entries at or above NBYTES are never written and stay zero.
  localparam int              DEPTH = 2 ** CW;
  localparam logic [CW-1:0]   LAST  = CW'(NBYTES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] idx_nxt;
  logic          carry_q, carry_d;
  logic [7:0]    a_q [DEPTH];
  logic [7:0]    a_d [DEPTH];
  logic [7:0]    b_q [DEPTH];
  logic [7:0]    b_d [DEPTH];
  logic [7:0]    s_q [DEPTH];
  logic [7:0]    s_d [DEPTH];
  logic [7:0]    add_a_q, add_a_d;
  logic [7:0]    add_b_q, add_b_d;
  logic          add_cin_q, add_cin_d;
  logic          idx_last;

  assign idx_nxt  = idx_q + CW'(1);
  assign idx_last = (idx_q == LAST);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    s_d       = s_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    add_cin_d = add_cin_q;

    case (state_q)
      LOAD_A: begin
        if (in_valid) begin
          a_d[idx_q] = in_data;
          if (idx_q == '0) carry_d = in_cin;
          if (idx_last) begin
            idx_d   = '0;
            state_d = LOAD_B;
          end else begin
            idx_d = idx_nxt;
          end
        end
      end
      LOAD_B: begin
        if (in_valid) begin
          b_d[idx_q] = in_data;
          if (idx_last) begin
            idx_d     = '0;
            state_d   = ADD;
            // Preload byte 0 so the adder operands come straight from flops
            // in the first ADD cycle. With a single byte, B[0] is the byte
            // being written right now.
            add_a_d   = a_q[0];
            add_b_d   = (idx_q == '0) ? in_data : b_q[0];
            add_cin_d = carry_q;
          end else begin
            idx_d = idx_nxt;
          end
        end
      end
      ADD: begin
        s_d[idx_q] = add_sum;
        carry_d    = add_cout;
        if (idx_last) begin
          idx_d   = '0;
          state_d = DRAIN;
        end else begin
          idx_d     = idx_nxt;
          add_a_d   = a_q[idx_nxt];
          add_b_d   = b_q[idx_nxt];
          add_cin_d = add_cout;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (idx_last) begin
            idx_d   = '0;
            state_d = LOAD_A;
          end else begin
            idx_d = idx_nxt;
          end
        end
      end
      default: begin
        state_d = LOAD_A;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= LOAD_A;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      a_q       <= '{default: '0};
      b_q       <= '{default: '0};
      s_q       <= '{default: '0};
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      a_q       <= a_d;
      b_q       <= b_d;
      s_q       <= s_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_cin_q <= add_cin_d;
    end
  end

  assign in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign out_valid = (state_q == DRAIN);
  assign out_data  = s_q[idx_q];
  assign out_last  = out_valid && idx_last;
  assign out_cout  = out_last && carry_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign busy      = !((state_q == LOAD_A) && (idx_q == '0));

endmodule

// File: tb/tb_csa_operand_sequencer.sv
module tb_csa_operand_sequencer;

  localparam int NB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       in_cin;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic       add_cin;
  logic [7:0] add_sum;
  logic       add_cout;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       out_cout;
  logic       busy;

  int errors = 0;
  int checks = 0;

  csa_operand_sequencer #(.NBYTES(NB), .CW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cin    (in_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural 8-bit adder slice.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 9'(add_cin);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic c);
    int n;
    n = 0;
    in_data  = d;
    in_cin   = c;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_wait", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int g = 0; g < n; g++) tick();
  endtask

  // One complete addition: load A then B (with optional idle gaps between
  // bytes), check adder operands through ADD, then drain with optional
  // backpressure on one byte. bp_byte >= NB means no backpressure.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input int gap, input int bp_byte, input int bp_len, input bit junk);
    logic [32:0] full;
    logic [63:0] m;
    logic [63:0] lo;
    int k;
    full = {1'b0, a} + {1'b0, b} + 33'(cin);
    for (int i = 0; i < NB; i++) begin
      send_byte(a[8*i +: 8], cin);
      if (i == 0) chk("busy_load", busy, 1'b1);
      idle(gap);
    end
    for (int i = 0; i < NB; i++) begin
      send_byte(b[8*i +: 8], 1'b0);
      if (i < NB - 1) idle(gap);
    end
    if (junk) begin
      in_valid = 1'b1;
      in_data  = 8'hA5;
      in_cin   = 1'b1;
    end
    k = 0;
    while (!out_valid && k < 40) begin
      chk("in_ready_add", in_ready, 1'b0);
      if (k < NB) begin
        m  = (64'd1 << (8 * k)) - 64'd1;
        lo = ((64'(a) & m) + (64'(b) & m) + 64'(cin)) >> (8 * k);
        chk("add_a", add_a, a[8*k +: 8]);
        chk("add_b", add_b, b[8*k +: 8]);
        chk("add_cin", add_cin, lo[0]);
      end
      tick();
      k++;
    end
    chk("first_valid", out_valid, 1'b1);
    chk("latency", k + 1, NB + 1);
    for (int i = 0; i < NB; i++) begin
      if (i == bp_byte) begin
        out_ready = 1'b0;
        for (int j = 0; j < bp_len; j++) begin
          tick();
          chk("bp_valid", out_valid, 1'b1);
          chk("bp_data", out_data, full[8*i +: 8]);
          chk("bp_last", out_last, i == NB - 1);
        end
        out_ready = 1'b1;
      end
      chk("out_valid", out_valid, 1'b1);
      chk("in_ready_drain", in_ready, 1'b0);
      chk("out_data", out_data, full[8*i +: 8]);
      chk("out_last", out_last, i == NB - 1);
      chk("out_cout", out_cout, (i == NB - 1) ? full[32] : 1'b0);
      tick();
    end
    in_valid = 1'b0;
    chk("idle_in_ready", in_ready, 1'b1);
    chk("idle_out_valid", out_valid, 1'b0);
    chk("idle_busy", busy, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_cin    = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_cout", out_cout, 1'b0);
    chk("rst_add_a", add_a, 8'h00);
    chk("rst_add_b", add_b, 8'h00);
    chk("rst_add_cin", add_cin, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic carry across byte 0.
    run_op(32'h000000FF, 32'h00000001, 1'b0, 0, NB, 0, 1'b0);
    // Carry ripples through every byte into out_cout.
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 0, NB, 0, 1'b0);
    // Back-to-back: previous carry must not leak.
    run_op(32'h00000000, 32'h00000000, 1'b0, 0, NB, 0, 1'b0);
    // Backpressure on byte 1 for 3 cycles.
    run_op(32'h12345678, 32'h11111111, 1'b0, 0, 1, 3, 1'b0);
    // Input stalls between bytes and junk offered during ADD/DRAIN.
    run_op(32'h12345678, 32'h11111111, 1'b0, 2, NB, 0, 1'b1);

    // Reset after 5 loaded bytes.
    for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i), 1'b1);
    chk("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    run_op(32'h00000001, 32'h00000002, 1'b0, 0, NB, 0, 1'b0);

    // Randomized operands, stalls and backpressure.
    for (int r = 0; r < 20; r++) begin
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
             int'($urandom_range(0, NB)), int'($urandom_range(1, 3)),
             1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
